pattern_ring_rotator: RTL and testbench

Parametrised, loadable pattern register that steps a WIDTH-bit pattern through rotate, Johnson or bounce (ping-pong) sequences under a programmable prescaler. It is the general successor to the team's fixed 3-bit load/rotate ring used for segment animations. It sits between a tt_um top-level (ui_in/uio_in pins driving the controls) and the segment or LED outputs.

---
 rtl/pattern_ring_rotator.sv | 143 ++++++++++++++
 tb/tb_pattern_ring_rotator.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_ring_rotator.sv
// pattern_ring_rotator: loadable WIDTH-bit pattern register that steps its
// contents through rotate, Johnson or bounce (ping-pong) sequences. A
// programmable prescaler sets the step period to div+1 clock cycles.
// step_o and wrap_o are one-cycle registered pulses that report each step,
// and each step that returns q to the most recently loaded pattern.
module pattern_ring_rotator #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DIV_W     = 8,
    parameter int unsigned RESET_VAL = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             run,
    input  logic [1:0]       mode,
    input  logic             dir,
    input  logic [DIV_W-1:0] div,
    output logic [WIDTH-1:0] q,
    output logic             dir_o,
    output logic             step_o,
    output logic             wrap_o
);

    typedef enum logic [1:0] {
        MODE_ROTATE  = 2'b00,
        MODE_JOHNSON = 2'b01,
        MODE_BOUNCE  = 2'b10,
        MODE_HOLD    = 2'b11
    } mode_e;

    // The reset pattern is RESET_VAL zero-extended (or truncated) to WIDTH bits.
    localparam logic [WIDTH-1:0] RST_Q = WIDTH'(RESET_VAL);

    // Architectural state.
    logic [WIDTH-1:0] ref_q;      // last loaded pattern, compared to find a wrap
    logic [DIV_W-1:0] cnt;        // prescaler count

    // Candidate values for a step, and next-state values for every register.
    logic [WIDTH-1:0] step_q;
    logic             step_dir;
    logic [WIDTH-1:0] q_nxt;
    logic [WIDTH-1:0] ref_nxt;
    logic [DIV_W-1:0] cnt_nxt;
    logic             dir_nxt;
    logic             step_nxt;
    logic             wrap_nxt;

    // Pattern and bounce direction that a step would produce in the current mode.
    always_comb begin
        // NOTE: every output of this block gets a default first. A path that
        // leaves one unassigned would infer a latch.
        step_q   = q;
        step_dir = dir_o;
        case (mode_e'(mode))
            MODE_ROTATE: begin
                if (dir) begin
                    step_q = {q[0], q[WIDTH-1:1]};
                end else begin
                    step_q = {q[WIDTH-2:0], q[WIDTH-1]};
                end
            end
            MODE_JOHNSON: begin
                if (dir) begin
                    step_q = {~q[0], q[WIDTH-1:1]};
                end else begin
                    step_q = {q[WIDTH-2:0], ~q[WIDTH-1]};
                end
            end
            MODE_BOUNCE: begin
                // Zero-fill shift. The direction reverses once a set bit
                // reaches the leading edge. An all-zero pattern never reverses.
                if (dir_o) begin
                    step_q = {1'b0, q[WIDTH-1:1]};
                    if (step_q[0]) begin
                        step_dir = 1'b0;
                    end
                end else begin
                    step_q = {q[WIDTH-2:0], 1'b0};
                    if (step_q[WIDTH-1]) begin
                        step_dir = 1'b1;
                    end
                end
            end
            default: begin
                // Hold: the step still happens, but the pattern does not change.
                step_q   = q;
                step_dir = dir_o;
            end
        endcase
    end

    // Per-edge priority: load beats step, and step beats counting or idling.
    always_comb begin
        q_nxt    = q;
        ref_nxt  = ref_q;
        dir_nxt  = dir_o;
        cnt_nxt  = cnt;
        step_nxt = 1'b0;
        wrap_nxt = 1'b0;
        if (load) begin
            // A load also restarts the prescaler, so any step that was due is dropped.
            q_nxt   = load_data;
            ref_nxt = load_data;
            dir_nxt = dir;
            cnt_nxt = '0;
        end else if (!run) begin
            cnt_nxt = '0;
        end else if (cnt >= div) begin
            // Compare with >= rather than ==, so that lowering div below the
            // current count fires on the next edge instead of wrapping the counter.
            q_nxt    = step_q;
            dir_nxt  = step_dir;
            cnt_nxt  = '0;
            step_nxt = 1'b1;
            wrap_nxt = (step_q == ref_q);
        end else begin
            cnt_nxt = cnt + DIV_W'(1);
        end
    end

    // State register: every output is registered, so no input reaches an output combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= RST_Q;
            ref_q  <= RST_Q;
            dir_o  <= 1'b0;
            cnt    <= '0;
            step_o <= 1'b0;
            wrap_o <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments. Every register here samples the
            // values from before the edge, whatever order the lines are in.
            q      <= q_nxt;
            ref_q  <= ref_nxt;
            dir_o  <= dir_nxt;
            cnt    <= cnt_nxt;
            step_o <= step_nxt;
            wrap_o <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_pattern_ring_rotator.sv
// Self-checking bench for pattern_ring_rotator (WIDTH=8, DIV_W=8, RESET_VAL=1).
// On every clock the expected outputs are pushed to a scoreboard queue as the
// stimulus is applied. They are popped and compared once the DUT has clocked.
// Fixed reference values for the key points of each sequence are also checked directly.
module tb_pattern_ring_rotator;

    localparam int W  = 8;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load;
    logic [W-1:0]  load_data;
    logic          run;
    logic [1:0]    mode;
    logic          dir;
    logic [DW-1:0] div;
    logic [W-1:0]  q;
    logic          dir_o;
    logic          step_o;
    logic          wrap_o;

    pattern_ring_rotator #(
        .WIDTH    (W),
        .DIV_W    (DW),
        .RESET_VAL(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (load),
        .load_data(load_data),
        .run      (run),
        .mode     (mode),
        .dir      (dir),
        .div      (div),
        .q        (q),
        .dir_o    (dir_o),
        .step_o   (step_o),
        .wrap_o   (wrap_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        string        tag;
        logic [W-1:0] q;
        logic         dir;
        logic         step;
        logic         wrap;
    } exp_t;

    exp_t sb[$];
    int   n_compared = 0;
    int   n_mismatch = 0;

    // Reference model state, taken after the most recent edge.
    logic [W-1:0] m_q;
    logic [W-1:0] m_ref;
    logic         m_dir;
    int           m_cnt;
    logic         m_step;
    logic         m_wrap;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatch++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q    = 8'h01;
        m_ref  = 8'h01;
        m_dir  = 1'b0;
        m_cnt  = 0;
        m_step = 1'b0;
        m_wrap = 1'b0;
    endtask

    // One step of the pattern, written with shifts and masks.
    task automatic model_step();
        logic [W-1:0] v;
        v = m_q;
        case (mode)
            2'd0: m_q = dir ? ((v >> 1) | (v << (W - 1))) : ((v << 1) | (v >> (W - 1)));
            2'd1: m_q = dir ? ((v >> 1) | ({7'd0, ~v[0]} << (W - 1)))
                            : ((v << 1) | {7'd0, ~v[W-1]});
            2'd2: begin
                if (!m_dir) begin
                    m_q = v << 1;
                    if (m_q[W-1]) m_dir = 1'b1;
                end else begin
                    m_q = v >> 1;
                    if (m_q[0]) m_dir = 1'b0;
                end
            end
            default: m_q = v;
        endcase
    endtask

    // Predict the result of the coming edge and push it, then clock and compare.
    task automatic tick(input string tag);
        exp_t e;
        if (load) begin
            m_q    = load_data;
            m_ref  = load_data;
            m_dir  = dir;
            m_cnt  = 0;
            m_step = 1'b0;
            m_wrap = 1'b0;
        end else if (!run) begin
            m_cnt  = 0;
            m_step = 1'b0;
            m_wrap = 1'b0;
        end else if (m_cnt >= int'(div)) begin
            model_step();
            m_cnt  = 0;
            m_step = 1'b1;
            m_wrap = (m_q == m_ref);
        end else begin
            m_cnt++;
            m_step = 1'b0;
            m_wrap = 1'b0;
        end
        e.tag  = tag;
        e.q    = m_q;
        e.dir  = m_dir;
        e.step = m_step;
        e.wrap = m_wrap;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, ".q"}, 32'(q), 32'(e.q));
            check({e.tag, ".dir_o"}, 32'(dir_o), 32'(e.dir));
            check({e.tag, ".step_o"}, 32'(step_o), 32'(e.step));
            check({e.tag, ".wrap_o"}, 32'(wrap_o), 32'(e.wrap));
        end
    endtask

    task automatic do_load(input logic [W-1:0] data, input logic [1:0] md, input logic d);
        load      = 1'b1;
        load_data = data;
        mode      = md;
        dir       = d;
        tick("load");
        load = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int wraps;
        int steps;

        rst_n     = 1'b0;
        load      = 1'b0;
        load_data = '0;
        run       = 1'b0;
        mode      = 2'd0;
        dir       = 1'b0;
        div       = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("rst.q", 32'(q), 32'h01);
        check("rst.dir_o", 32'(dir_o), 32'd0);
        check("rst.step_o", 32'(step_o), 32'd0);
        check("rst.wrap_o", 32'(wrap_o), 32'd0);
        rst_n = 1'b1;
        tick("idle");
        tick("idle");

        // Rotate left from 0x81. The 8th step brings the pattern back and must flag a wrap.
        run = 1'b1;
        do_load(8'h81, 2'd0, 1'b0);
        check("rot.load_q", 32'(q), 32'h81);
        wraps = 0;
        for (int i = 1; i <= 8; i++) begin
            tick("rot");
            if (wrap_o) wraps++;
            if (i == 1) check("rot.first", 32'(q), 32'h03);
            if (i == 8) check("rot.last", 32'(q), 32'h81);
            if (i == 8) check("rot.wrap", 32'(wrap_o), 32'd1);
        end
        check("rot.wrap_count", 32'(wraps), 32'd1);

        // Johnson left from 0x00: 16 steps long.
        do_load(8'h00, 2'd1, 1'b0);
        wraps = 0;
        for (int i = 1; i <= 16; i++) begin
            tick("john");
            if (wrap_o) wraps++;
            if (i == 8) check("john.full", 32'(q), 32'hFF);
            if (i == 9) check("john.drain", 32'(q), 32'hFE);
            if (i == 16) check("john.end", 32'(q), 32'h00);
        end
        check("john.wrap_count", 32'(wraps), 32'd1);

        // Bounce from 0x01. The dir input changes after the load and must be ignored.
        do_load(8'h01, 2'd2, 1'b0);
        dir   = 1'b1;
        wraps = 0;
        for (int i = 1; i <= 14; i++) begin
            tick("bounce");
            if (wrap_o) wraps++;
            if (i == 7) check("bounce.top_q", 32'(q), 32'h80);
            if (i == 7) check("bounce.top_dir", 32'(dir_o), 32'd1);
            if (i == 8) check("bounce.back", 32'(q), 32'h40);
            if (i == 14) check("bounce.end_q", 32'(q), 32'h01);
            if (i == 14) check("bounce.end_dir", 32'(dir_o), 32'd0);
        end
        check("bounce.wrap_count", 32'(wraps), 32'd1);

        // Right rotate, then right Johnson, then hold. The scoreboard covers every cycle.
        do_load(8'h01, 2'd0, 1'b1);
        tick("rot_r");
        check("rot_r.first", 32'(q), 32'h80);
        repeat (2) tick("rot_r");
        mode = 2'd1;
        repeat (3) tick("john_r");
        mode = 2'd3;
        repeat (3) tick("hold");
        check("hold.step", 32'(step_o), 32'd1);

        // Prescaler: div=3 gives exactly three steps in 12 cycles.
        run = 1'b0;
        div = 8'd3;
        do_load(8'h01, 2'd0, 1'b0);
        run   = 1'b1;
        steps = 0;
        for (int i = 1; i <= 12; i++) begin
            tick("presc");
            if (step_o) steps++;
        end
        check("presc.steps", 32'(steps), 32'd3);
        check("presc.q", 32'(q), 32'h08);
        run   = 1'b0;
        steps = 0;
        repeat (5) begin
            tick("frozen");
            if (step_o) steps++;
        end
        check("frozen.steps", 32'(steps), 32'd0);
        check("frozen.q", 32'(q), 32'h08);
        run = 1'b1;
        repeat (2) tick("presc_cnt");
        div = 8'd1;
        tick("div_drop");
        check("div_drop.step", 32'(step_o), 32'd1);
        check("div_drop.q", 32'(q), 32'h10);

        // A load on the same edge as a due step: the load wins and the count restarts.
        div = 8'd3;
        repeat (3) tick("pre_collide");
        load      = 1'b1;
        load_data = 8'h55;
        tick("collide");
        load = 1'b0;
        check("collide.q", 32'(q), 32'h55);
        check("collide.step", 32'(step_o), 32'd0);
        steps = 0;
        repeat (3) begin
            tick("post_collide");
            if (step_o) steps++;
        end
        check("post_collide.early", 32'(steps), 32'd0);
        tick("post_collide");
        check("post_collide.step", 32'(step_o), 32'd1);
        check("post_collide.q", 32'(q), 32'hAA);

        // Asynchronous reset mid-run. Outputs must clear before any clock edge.
        div = 8'd0;
        do_load(8'h80, 2'd2, 1'b1);
        repeat (2) tick("pre_reset");
        rst_n = 1'b0;
        #2;
        check("async_rst.q", 32'(q), 32'h01);
        check("async_rst.dir_o", 32'(dir_o), 32'd0);
        check("async_rst.step_o", 32'(step_o), 32'd0);
        check("async_rst.wrap_o", 32'(wrap_o), 32'd0);
        model_reset();
        #2;
        rst_n = 1'b1;
        mode  = 2'd0;
        dir   = 1'b0;
        div   = 8'd2;
        steps = 0;
        repeat (2) begin
            tick("post_reset");
            if (step_o) steps++;
        end
        check("post_reset.early", 32'(steps), 32'd0);
        tick("post_reset");
        check("post_reset.step", 32'(step_o), 32'd1);
        check("post_reset.q", 32'(q), 32'h02);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
